// File: rtl/ex_pkg.sv
// -----------------------------------------------------------------------------
// ex_pkg
// Shared types and constants for the LEGv8 execute stage.
//   ctrl_t      : pipeline control bits {regwrite, memread, memwrite, memtoreg, branch}
//   A_* / MOVZ_*: 4-bit ALU control codes produced by the ALU control decoder
//   XZR         : zero register number, never a forwarding source
//   fwd_hit     : forwarding match helper used for both source operands
// -----------------------------------------------------------------------------
package ex_pkg;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic branch;
    } ctrl_t;

    localparam logic [3:0] A_AND_B      = 4'b0000;
    localparam logic [3:0] A_OR_B       = 4'b0001;
    localparam logic [3:0] A_PLUS_B     = 4'b0010;
    localparam logic [3:0] A_MINUS_B    = 4'b0110;
    localparam logic [3:0] PASS_INPUT_B = 4'b0111;
    localparam logic [3:0] MOVZ_B_00    = 4'b1000;
    localparam logic [3:0] MOVZ_B_01    = 4'b1001;
    localparam logic [3:0] MOVZ_B_10    = 4'b1010;
    localparam logic [3:0] MOVZ_B_11    = 4'b1011;

    localparam logic [4:0] XZR = 5'd31;

    // A producer forwards to a source register only if it writes that
    // register and the register is not XZR (reads of XZR are always zero).
    function automatic logic fwd_hit(input logic       wr_en,
                                     input logic [4:0] dst,
                                     input logic [4:0] src);
        return wr_en && (dst == src) && (src != XZR);
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// -----------------------------------------------------------------------------
// alu
// Combinational LEGv8 ALU for the execute stage.
//   a_i, b_i       in  N  operands (B already muxed between immediate and rd2)
//   alucontrol_i   in  4  decoded ALU control code
//   result_o       out N  operation result, wraps modulo 2^N
//   zero_o         out 1  result == 0
//   nzcv_o         out 4  {N,Z,C,V}; only computed when EX_NZCV_EN is defined,
//                         otherwise tied to 4'b0000
// -----------------------------------------------------------------------------
module alu
    import ex_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [3:0]   alucontrol_i,
    output logic [N-1:0] result_o,
    output logic         zero_o,
    output logic [3:0]   nzcv_o
);

    logic [N-1:0] movz_base;

    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        result_o  = '0;
        movz_base = N'(b_i[15:0]);
        case (alucontrol_i)
            A_AND_B:      result_o = a_i & b_i;
            A_OR_B:       result_o = a_i | b_i;
            A_PLUS_B:     result_o = a_i + b_i;
            A_MINUS_B:    result_o = a_i - b_i;
            PASS_INPUT_B: result_o = b_i;
            // Low two code bits select the 16-bit halfword lane.
            MOVZ_B_00, MOVZ_B_01,
            MOVZ_B_10, MOVZ_B_11:
                          result_o = movz_base << {alucontrol_i[1:0], 4'b0000};
            default:      result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

`ifdef EX_NZCV_EN
    logic [N:0] sum_ext;
    logic [N:0] sub_ext;
    logic       flag_c;
    logic       flag_v;

    // Subtraction as A + ~B + 1 so the carry out is the no-borrow flag.
    assign sum_ext = {1'b0, a_i} + {1'b0, b_i};
    assign sub_ext = {1'b0, a_i} + {1'b0, ~b_i} + (N+1)'(1);

    always_comb begin
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (alucontrol_i)
            A_PLUS_B: begin
                flag_c = sum_ext[N];
                flag_v = (a_i[N-1] == b_i[N-1]) && (sum_ext[N-1] != a_i[N-1]);
            end
            A_MINUS_B: begin
                flag_c = sub_ext[N];
                flag_v = (a_i[N-1] != b_i[N-1]) && (sub_ext[N-1] != a_i[N-1]);
            end
            default: ;
        endcase
    end

    assign nzcv_o = {result_o[N-1], zero_o, flag_c, flag_v};
`else
    assign nzcv_o = 4'b0000;
`endif

endmodule

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
// Execute stage of the 5-stage LEGv8 pipeline: ID/EX register, forwarding
// muxes, ALU and EX/MEM register. Two-cycle latency, one instruction per cycle.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   id_stall, flush     : bubble ID/EX (stall) / bubble both registers (flush)
//   id_*                : decoded instruction fields from ID
//   wb_regwrite/rd/data : WB-stage write port, used as forwarding source
//   exmem_*             : registered EX results consumed by MEM
// Optional feature macro: EX_NZCV_EN (registered {N,Z,C,V} on exmem_nzcv;
// tied to zero when undefined).
// -----------------------------------------------------------------------------
module ex_stage
    import ex_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         id_stall,
    input  logic         flush,
    input  logic [N-1:0] id_pc,
    input  logic [N-1:0] id_rd1,
    input  logic [N-1:0] id_rd2,
    input  logic [N-1:0] id_imm,
    input  logic [4:0]   id_rn,
    input  logic [4:0]   id_rm,
    input  logic [4:0]   id_rd,
    input  logic [3:0]   id_alucontrol,
    input  logic         id_alusrc,
    input  logic [4:0]   id_ctrl,
    input  logic         wb_regwrite,
    input  logic [4:0]   wb_rd,
    input  logic [N-1:0] wb_data,
    output logic         exmem_valid,
    output logic [4:0]   exmem_ctrl,
    output logic [N-1:0] exmem_aluresult,
    output logic         exmem_zero,
    output logic [N-1:0] exmem_writedata,
    output logic [4:0]   exmem_rd,
    output logic [N-1:0] exmem_branch_target,
    output logic [3:0]   exmem_nzcv
);

    // ID/EX register
    logic         idex_valid_q;
    ctrl_t        idex_ctrl_q;
    logic [N-1:0] idex_pc_q, idex_rd1_q, idex_rd2_q, idex_imm_q;
    logic [4:0]   idex_rn_q, idex_rm_q, idex_rd_q;
    logic [3:0]   idex_alucontrol_q;
    logic         idex_alusrc_q;

    // EX/MEM register
    logic         exmem_valid_q;
    ctrl_t        exmem_ctrl_q;
    logic [N-1:0] exmem_aluresult_q, exmem_writedata_q, exmem_target_q;
    logic         exmem_zero_q;
    logic [4:0]   exmem_rd_q;
    logic [3:0]   exmem_nzcv_q;

    // EX-cycle next-state values for EX/MEM
    logic [N-1:0] fwd_a, fwd_b, alu_b;
    logic [N-1:0] ex_result_d, ex_target_d;
    logic         ex_zero_d;
    logic [3:0]   ex_nzcv_d;
    logic         exmem_fwd_en;

    // Stall and flush both insert the same all-zero bubble, so they share the
    // reset branch.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || flush || id_stall) begin
            idex_valid_q      <= 1'b0;
            idex_ctrl_q       <= '0;
            idex_pc_q         <= '0;
            idex_rd1_q        <= '0;
            idex_rd2_q        <= '0;
            idex_imm_q        <= '0;
            idex_rn_q         <= '0;
            idex_rm_q         <= '0;
            idex_rd_q         <= '0;
            idex_alucontrol_q <= '0;
            idex_alusrc_q     <= 1'b0;
        end else begin
            idex_valid_q      <= 1'b1;
            idex_ctrl_q       <= ctrl_t'(id_ctrl);
            idex_pc_q         <= id_pc;
            idex_rd1_q        <= id_rd1;
            idex_rd2_q        <= id_rd2;
            idex_imm_q        <= id_imm;
            idex_rn_q         <= id_rn;
            idex_rm_q         <= id_rm;
            idex_rd_q         <= id_rd;
            idex_alucontrol_q <= id_alucontrol;
            idex_alusrc_q     <= id_alusrc;
        end
    end

    // A load's EX/MEM value is an address, not the loaded data, so it is
    // excluded here; the hazard unit stalls that case instead.
    assign exmem_fwd_en = exmem_valid_q && exmem_ctrl_q.regwrite && !exmem_ctrl_q.memtoreg;

    // EX/MEM is the younger producer and takes priority over WB.
    always_comb begin
        fwd_a = idex_rd1_q;
        if (fwd_hit(exmem_fwd_en, exmem_rd_q, idex_rn_q))
            fwd_a = exmem_aluresult_q;
        else if (fwd_hit(wb_regwrite, wb_rd, idex_rn_q))
            fwd_a = wb_data;

        fwd_b = idex_rd2_q;
        if (fwd_hit(exmem_fwd_en, exmem_rd_q, idex_rm_q))
            fwd_b = exmem_aluresult_q;
        else if (fwd_hit(wb_regwrite, wb_rd, idex_rm_q))
            fwd_b = wb_data;
    end

    assign alu_b       = idex_alusrc_q ? idex_imm_q : fwd_b;
    assign ex_target_d = idex_pc_q + (idex_imm_q << 2);

    alu #(.N(N)) u_alu (
        .a_i          (fwd_a),
        .b_i          (alu_b),
        .alucontrol_i (idex_alucontrol_q),
        .result_o     (ex_result_d),
        .zero_o       (ex_zero_d),
        .nzcv_o       (ex_nzcv_d)
    );

    // A bubble arriving from ID/EX is stored as all zeros, the same as a flush,
    // so MEM never sees flags or data from an instruction that does not exist.
    always_ff @(posedge clk) begin
        if (reset || flush || !idex_valid_q) begin
            exmem_valid_q     <= 1'b0;
            exmem_ctrl_q      <= '0;
            exmem_aluresult_q <= '0;
            exmem_zero_q      <= 1'b0;
            exmem_writedata_q <= '0;
            exmem_rd_q        <= '0;
            exmem_target_q    <= '0;
            exmem_nzcv_q      <= '0;
        end else begin
            exmem_valid_q     <= 1'b1;
            exmem_ctrl_q      <= idex_ctrl_q;
            exmem_aluresult_q <= ex_result_d;
            exmem_zero_q      <= ex_zero_d;
            exmem_writedata_q <= fwd_b;
            exmem_rd_q        <= idex_rd_q;
            exmem_target_q    <= ex_target_d;
            exmem_nzcv_q      <= ex_nzcv_d;
        end
    end

    assign exmem_valid         = exmem_valid_q;
    assign exmem_ctrl          = exmem_ctrl_q;
    assign exmem_aluresult     = exmem_aluresult_q;
    assign exmem_zero          = exmem_zero_q;
    assign exmem_writedata     = exmem_writedata_q;
    assign exmem_rd            = exmem_rd_q;
    assign exmem_branch_target = exmem_target_q;
    assign exmem_nzcv          = exmem_nzcv_q;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage LEGv8 pipeline, sitting directly downstream of the ALU control decoder.
- Contains the ID/EX register, the forwarding muxes, the ALU (driven by the decoded 4-bit ALU control) and the EX/MEM register.
- Produces the ALU result, zero flag, store data, branch target and the forwarded control bits consumed by the MEM stage.

Parameters:
- N, 64, datapath width in bits.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- id_stall  in  1  load-use stall from hazard unit; insert bubble into EX
- flush  in  1  taken branch resolved in MEM; kill EX and EX/MEM contents
- id_pc  in  N  PC of instruction in ID
- id_rd1  in  N  register file read data 1 (Rn)
- id_rd2  in  N  register file read data 2 (Rm or Rt)
- id_imm  in  N  extended immediate from ID
- id_rn  in  5  Rn number
- id_rm  in  5  second source register number
- id_rd  in  5  destination register number
- id_alucontrol  in  4  ALU control code from the ALU control decoder
- id_alusrc  in  1  1: ALU B = immediate; 0: ALU B = forwarded rd2
- id_ctrl  in  5  ctrl_t {regwrite, memread, memwrite, memtoreg, branch}
- wb_regwrite  in  1  WB stage write enable
- wb_rd  in  5  WB destination register number
- wb_data  in  N  WB write data
- exmem_valid  out  1  EX/MEM holds a real instruction
- exmem_ctrl  out  5  registered ctrl_t
- exmem_aluresult  out  N  registered ALU result
- exmem_zero  out  1  registered (ALU result == 0)
- exmem_writedata  out  N  registered forwarded rd2 (STUR data)
- exmem_rd  out  5  registered destination register
- exmem_branch_target  out  N  registered PC + (imm << 2)
- exmem_nzcv  out  4  registered flags (optional feature)

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-high. On a reset edge, both registers are cleared: every output is 0, and the ID/EX valid bit and ctrl are 0.
- Latency: ID inputs are sampled at edge k into ID/EX. The ALU evaluates during cycle k+1. Results appear on the exmem_* outputs after edge k+1, giving 2-cycle latency. Throughput is 1 per cycle.
- ID/EX update priority per edge: reset > flush > id_stall > load.
  - flush or id_stall loads a bubble: valid=0, ctrl=0, all data fields 0.
  - Otherwise ID/EX captures all id_* inputs with valid=1.
- EX/MEM update priority per edge: reset > flush > load.
  - flush loads a bubble.
  - Otherwise EX/MEM captures the EX results, including bubbles propagating from ID/EX.
  - id_stall does not freeze EX/MEM.
- Forwarding: applied per operand (A from Rn, B-register from Rm) to the ID/EX register values.
  - Priority 1, from EX/MEM: exmem_valid & exmem_ctrl.regwrite & !exmem_ctrl.memtoreg & exmem_rd == src & src != 31. Operand takes exmem_aluresult.
  - Priority 2, from WB: wb_regwrite & wb_rd == src & src != 31. Operand takes wb_data.
  - Otherwise the operand takes the ID/EX read data.
  - Register 31 (XZR) is never forwarded.
  - A load result held in EX/MEM is never forwarded; the hazard unit's id_stall covers that case.
- ALU B operand: id_alusrc ? imm : forwarded rd2. exmem_writedata is always the forwarded rd2.
- ALU operations, all results N bits wide, wrapping modulo 2^N:
  - A_AND_B: A & B
  - A_OR_B: A | B
  - A_PLUS_B: A + B
  - A_MINUS_B: A - B
  - PASS_INPUT_B: B
  - MOVZ_B_00..MOVZ_B_11: {48'b0, B[15:0]} << (16*k) for k = 0..3
  - Any other code: result 0.
- zero = (result == 0) is registered. CBZ resolves in MEM from exmem_zero.
- branch_target = ID/EX pc + (imm << 2), truncated to N bits.
- Simultaneous flush and id_stall: flush wins; both registers are bubbled.
- Reset asserted mid-stream: any in-flight instruction is discarded; there is no partial state.

Optional Feature:
- Macro: EX_NZCV_EN.
- Defined: exmem_nzcv = {N, Z, C, V} of the EX result, registered with the other EX/MEM fields.
  - A_PLUS_B: C = carry out; V = signed overflow.
  - A_MINUS_B: C = no-borrow (A >= B unsigned); V = signed overflow.
  - Logical and move codes: C = V = 0; N and Z taken from the result.
  - Bubbles load 0.
- Undefined: exmem_nzcv is tied to 4'b0000. No flag logic is synthesised.

Decomposition:
- Package ex_pkg:
  - ctrl_t packed struct {regwrite, memread, memwrite, memtoreg, branch}.
  - 4-bit ALU code constants: A_AND_B=0000, A_OR_B=0001, A_PLUS_B=0010, A_MINUS_B=0110, PASS_INPUT_B=0111, MOVZ_B_00..11=1000..1011.
  - XZR=5'd31.
- Sub-module: alu (combinational: a, b, alucontrol -> result, zero, nzcv). ex_stage instantiates it between the two registers.

Test Plan:
- Reset, then ADD with rd1=5, rd2=7, alusrc=0, A_PLUS_B, rd=3, regwrite -> two edges later exmem_aluresult=12, exmem_zero=0, exmem_valid=1, exmem_rd=3.
- Back-to-back dependency: ADD X3 = 5+7, then SUB X4 = X3 - X1 with stale rd1=0 and rd2(X1)=2 -> EX/MEM forward gives exmem_aluresult=10. Repeat with rd=31 -> no forward, result 0-2=0xFFFF_FFFF_FFFF_FFFE.
- WB vs EX/MEM priority: wb_rd=3, wb_data=100 and EX/MEM rd=3 with result 12 -> operand uses 12. If EX/MEM is memtoreg (load) -> operand uses 100.
- MOVZ: imm=0x1234, MOVZ_B_10 -> 0x0000_1234_0000_0000. CBZ with PASS_INPUT_B and forwarded rd2=0 -> exmem_zero=1. Branch target with pc=0x40, imm=3 -> 0x4C.
- Stall/flush: id_stall for one cycle -> next EX/MEM has valid=0, ctrl=0 while the previous instruction still completes. flush together with id_stall -> both registers bubbled on the same edge. reset mid-stream -> all outputs 0 on the next edge.
- EX_NZCV_EN defined: 0x7FFF_FFFF_FFFF_FFFF + 1 -> nzcv=1001. 5 - 5 with A_MINUS_B -> nzcv=0110. Undefined -> nzcv=0000 always.
